// File: rtl/sha_compress_if.sv
// sha_compress_if: bundle between the schedule stage and the compression stage.
// en/W/H_in flow into the compressor; H_out/done/busy flow back out.
interface sha_compress_if;
    logic          en;     // one-cycle start pulse
    logic [2047:0] W;      // expanded schedule, word t at [32t+31:32t]
    logic [255:0]  H_in;   // chaining value, H0 at [31:0]
    logic [255:0]  H_out;  // chaining value + final working variables
    logic          done;   // one-cycle completion pulse
    logic          busy;   // block in progress

    modport master (
        output en, W, H_in,
        input  H_out, done, busy
    );

    modport slave (
        input  en, W, H_in,
        output H_out, done, busy
    );
endinterface

// File: rtl/sha_compress.sv
// sha_compress: SHA-256 compression, one round per clock, then chaining add.
// Ports: clk, reset (async, active-high), bus (slave: en, W, H_in -> H_out, done, busy).
// Option: define SHA_LATCH_W_EN to capture W on the accepting en edge;
// otherwise W is read live each round and must be held through round 63.
module sha_compress #(
    parameter int ROUNDS = 64
) (
    input  logic          clk,
    input  logic          reset,
    sha_compress_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        ROUND,
        ADD
    } state_t;

    localparam logic [5:0] LAST = 6'(ROUNDS - 1);

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] rotr(
        input logic [31:0] x,
        input int          n
    );
        return (x >> n) | (x << (32 - n));
    endfunction

    state_t        state_q;
    logic [5:0]    t_q;
    logic [31:0]   a_q, b_q, c_q, d_q;
    logic [31:0]   e_q, f_q, g_q, h_q;
    logic [255:0]  hs_q;
    logic [255:0]  h_out_q;
    logic          done_q;
    logic          busy_q;

    logic [2047:0] w_src;
    logic [31:0]   w_t;
    logic [31:0]   s0, s1, ch, maj;
    logic [31:0]   t1, t2;
    logic [31:0]   a_d, e_d;

`ifdef SHA_LATCH_W_EN
    logic [2047:0] w_q;
    assign w_src = w_q;
`else
    assign w_src = bus.W;
`endif

    // Round datapath; all sums wrap mod 2^32.
    always_comb begin
        w_t = w_src[{t_q, 5'd0} +: 32];
        s1  = rotr(e_q, 6) ^ rotr(e_q, 11) ^ rotr(e_q, 25);
        ch  = (e_q & f_q) ^ (~e_q & g_q);
        s0  = rotr(a_q, 2) ^ rotr(a_q, 13) ^ rotr(a_q, 22);
        maj = (a_q & b_q) ^ (a_q & c_q) ^ (b_q & c_q);
        t1  = h_q + s1 + ch + K[t_q] + w_t;
        t2  = s0 + maj;
        a_d = t1 + t2;
        e_d = d_q + t1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            t_q     <= 6'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            c_q     <= 32'd0;
            d_q     <= 32'd0;
            e_q     <= 32'd0;
            f_q     <= 32'd0;
            g_q     <= 32'd0;
            h_q     <= 32'd0;
            hs_q    <= 256'd0;
            h_out_q <= 256'd0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
`ifdef SHA_LATCH_W_EN
            w_q     <= 2048'd0;
`endif
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.en) begin
                        hs_q    <= bus.H_in;
                        a_q     <= bus.H_in[31:0];
                        b_q     <= bus.H_in[63:32];
                        c_q     <= bus.H_in[95:64];
                        d_q     <= bus.H_in[127:96];
                        e_q     <= bus.H_in[159:128];
                        f_q     <= bus.H_in[191:160];
                        g_q     <= bus.H_in[223:192];
                        h_q     <= bus.H_in[255:224];
                        t_q     <= 6'd0;
                        busy_q  <= 1'b1;
                        state_q <= ROUND;
`ifdef SHA_LATCH_W_EN
                        w_q     <= bus.W;
`endif
                    end
                end
                ROUND: begin
                    h_q <= g_q;
                    g_q <= f_q;
                    f_q <= e_q;
                    e_q <= e_d;
                    d_q <= c_q;
                    c_q <= b_q;
                    b_q <= a_q;
                    a_q <= a_d;
                    // Wraps to 0 as the last round completes.
                    t_q <= t_q + 6'd1;
                    if (t_q == LAST) begin
                        state_q <= ADD;
                    end
                end
                ADD: begin
                    h_out_q <= {
                        hs_q[255:224] + h_q,
                        hs_q[223:192] + g_q,
                        hs_q[191:160] + f_q,
                        hs_q[159:128] + e_q,
                        hs_q[127:96]  + d_q,
                        hs_q[95:64]   + c_q,
                        hs_q[63:32]   + b_q,
                        hs_q[31:0]    + a_q
                    };
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.H_out = h_out_q;
    assign bus.done  = done_q;
    assign bus.busy  = busy_q;

endmodule
